mlp: RTL and testbench

MLP -- requirements
Module: mlp

---
 rtl/mlp.sv | 241 ++++++++++++++++++++++++
 tb/tb_mlp.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp.sv
// Small fixed-point multilayer perceptron: one ReLU hidden layer and one
// linear output layer. A register port loads the inputs and weights, starts
// a run and reads back results. All arithmetic is signed Q8.8.
//
// Register write handshake: a write is taken on every rising clk edge where
// write_en is high. There is no back-pressure. readdata is registered. It
// always shows the value for the addr sampled on the previous edge.
module mlp #(
  parameter int N_INPUTS  = 2,
  parameter int N_HIDDEN  = 4,
  parameter int N_OUTPUT  = 1,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic [1:0]  addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [2:0]  dbg_state
);

  localparam int HW_N = N_HIDDEN * (N_INPUTS + 1);
  localparam int OW_N = N_OUTPUT * (N_HIDDEN + 1);
  localparam int IPW  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int HPW  = (HW_N > 1) ? $clog2(HW_N) : 1;
  localparam int OPW  = (OW_N > 1) ? $clog2(OW_N) : 1;
  localparam int HIW  = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
  localparam int OIW  = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
  localparam int MAXF = (N_INPUTS > N_HIDDEN) ? N_INPUTS : N_HIDDEN;
  localparam int MAXN = (N_HIDDEN > N_OUTPUT) ? N_HIDDEN : N_OUTPUT;
  localparam int CW   = $clog2(MAXF + 1);
  localparam int NW   = $clog2(MAXN + 1);
  localparam int AW   = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int PW   = AW + WGT_WIDTH;

  localparam logic signed [MAC_WIDTH-1:0] SAT_MAX =
    {{(MAC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [MAC_WIDTH-1:0] SAT_MIN =
    {{(MAC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HID_MAC = 3'd1,
    S_HID_ACT = 3'd2,
    S_OUT_MAC = 3'd3,
    S_OUT_ACT = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Storage
  logic signed [IN_WIDTH-1:0]  x_q   [N_INPUTS];
  logic signed [WGT_WIDTH-1:0] hw_q  [HW_N];
  logic signed [WGT_WIDTH-1:0] ow_q  [OW_N];
  logic signed [OUT_WIDTH-1:0] hid_q [N_HIDDEN];
  logic signed [OUT_WIDTH-1:0] out_q [N_OUTPUT];

  logic [IPW-1:0] in_ptr_q;
  logic [HPW-1:0] hw_ptr_q;
  logic [OPW-1:0] ow_ptr_q;
  logic           layer_sel_q;
  logic [3:0]     out_sel_q;
  logic           done_q;
  logic [31:0]    rdata_q;
  logic [CW-1:0]  idx_q;
  logic [NW-1:0]  neu_q;
  logic signed [MAC_WIDTH-1:0] acc_q;

  // FSM outputs
  logic busy, mac_en, act_en, act_hidden, fin_en;

  // Register-port decode
  logic wr_ctrl, wr_in, wr_w, start;
  logic unused_wd;

  assign wr_ctrl   = write_en && (addr == 2'd0);
  assign wr_in     = write_en && (addr == 2'd1) && !busy;
  assign wr_w      = write_en && (addr == 2'd2) && !busy;
  assign start     = wr_ctrl && writedata[0] && !busy;
  assign unused_wd = ^writedata;

  // Datapath operand selection and arithmetic
  logic [HPW-1:0] hw_sel;
  logic [OPW-1:0] ow_sel;
  logic [IPW-1:0] x_sel;
  logic [HIW-1:0] h_sel;
  logic signed [WGT_WIDTH-1:0] w_op;
  logic signed [AW-1:0]        x_op;
  logic signed [PW-1:0]        prod;
  logic signed [MAC_WIDTH-1:0] bias_acc, mac_sum, act_v;
  logic signed [OUT_WIDTH-1:0] act_sat, act_res;
  logic mac_last, neu_last;

  // Pick bias/weight and input for the current MAC step, then saturate for ACT
  always_comb begin
    hw_sel   = HPW'(int'(neu_q) * (N_INPUTS + 1) + int'(idx_q));
    ow_sel   = OPW'(int'(neu_q) * (N_HIDDEN + 1) + int'(idx_q));
    x_sel    = IPW'(int'(idx_q) - 1);
    h_sel    = HIW'(int'(idx_q) - 1);
    w_op     = (state_q == S_OUT_MAC) ? ow_q[ow_sel] : hw_q[hw_sel];
    x_op     = (state_q == S_OUT_MAC) ? AW'(hid_q[h_sel]) : AW'(x_q[x_sel]);
    prod     = w_op * x_op;
    bias_acc = MAC_WIDTH'(w_op) <<< 8;
    mac_sum  = acc_q + MAC_WIDTH'(prod);
    act_v    = acc_q >>> 8;
    if (act_v > SAT_MAX)      act_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (act_v < SAT_MIN) act_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                      act_sat = act_v[OUT_WIDTH-1:0];
    act_res  = (act_hidden && act_sat[OUT_WIDTH-1]) ? '0 : act_sat;
    mac_last = (state_q == S_HID_MAC) ? (idx_q == CW'(N_INPUTS))
                                      : (idx_q == CW'(N_HIDDEN));
    neu_last = (state_q == S_HID_ACT) ? (neu_q == NW'(N_HIDDEN - 1))
                                      : (neu_q == NW'(N_OUTPUT - 1));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: per neuron a MAC pass (bias + fanin steps) then one ACT step
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_HID_MAC;
      S_HID_MAC: if (mac_last) state_d = S_HID_ACT;
      S_HID_ACT: state_d = neu_last ? S_OUT_MAC : S_HID_MAC;
      S_OUT_MAC: if (mac_last) state_d = S_OUT_ACT;
      S_OUT_ACT: state_d = neu_last ? S_FIN : S_OUT_MAC;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy       = (state_q != S_IDLE);
    mac_en     = (state_q == S_HID_MAC) || (state_q == S_OUT_MAC);
    act_en     = (state_q == S_HID_ACT) || (state_q == S_OUT_ACT);
    act_hidden = (state_q == S_HID_ACT);
    fin_en     = (state_q == S_FIN);
  end

  // Control registers and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ptr_q    <= '0;
      hw_ptr_q    <= '0;
      ow_ptr_q    <= '0;
      layer_sel_q <= 1'b0;
      out_sel_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        out_sel_q <= writedata[7:4];
        if (!busy) begin
          in_ptr_q    <= '0;
          hw_ptr_q    <= '0;
          ow_ptr_q    <= '0;
          layer_sel_q <= writedata[3];
          done_q      <= 1'b0;
        end
      end
      if (wr_in)
        in_ptr_q <= (in_ptr_q == IPW'(N_INPUTS - 1)) ? '0 : in_ptr_q + 1'b1;
      if (wr_w && !layer_sel_q)
        hw_ptr_q <= (hw_ptr_q == HPW'(HW_N - 1)) ? '0 : hw_ptr_q + 1'b1;
      if (wr_w && layer_sel_q)
        ow_ptr_q <= (ow_ptr_q == OPW'(OW_N - 1)) ? '0 : ow_ptr_q + 1'b1;
      if (fin_en)
        done_q <= 1'b1;
    end
  end

  // Input and weight storage written through the register port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_INPUTS; i++) x_q[i]  <= '0;
      for (int i = 0; i < HW_N; i++)     hw_q[i] <= '0;
      for (int i = 0; i < OW_N; i++)     ow_q[i] <= '0;
    end else begin
      if (wr_in)
        x_q[in_ptr_q] <= writedata[IN_WIDTH-1:0];
      if (wr_w && !layer_sel_q)
        hw_q[hw_ptr_q] <= writedata[WGT_WIDTH-1:0];
      if (wr_w && layer_sel_q)
        ow_q[ow_ptr_q] <= writedata[WGT_WIDTH-1:0];
    end
  end

  // MAC accumulator, step/neuron counters and activation storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
      neu_q <= '0;
      for (int i = 0; i < N_HIDDEN; i++) hid_q[i] <= '0;
      for (int i = 0; i < N_OUTPUT; i++) out_q[i] <= '0;
    end else begin
      if (start) begin
        idx_q <= '0;
        neu_q <= '0;
      end
      if (mac_en) begin
        acc_q <= (idx_q == '0) ? bias_acc : mac_sum;
        idx_q <= idx_q + 1'b1;
      end
      if (act_en) begin
        idx_q <= '0;
        neu_q <= neu_last ? '0 : neu_q + 1'b1;
        if (act_hidden) hid_q[HIW'(neu_q)] <= act_res;
        else            out_q[OIW'(neu_q)] <= act_res;
      end
    end
  end

  // Registered read mux; out-of-range OUT_SEL reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      unique case (addr)
        2'd0:    rdata_q <= {24'd0, out_sel_q, layer_sel_q, busy, done_q, 1'b0};
        2'd3:    rdata_q <= (int'(out_sel_q) < N_OUTPUT) ? 32'(out_q[OIW'(out_sel_q)]) : 32'd0;
        default: rdata_q <= 32'd0;
      endcase
    end
  end

  assign readdata  = rdata_q;
  assign irq       = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mlp.sv
// Directed bench for mlp: loads Q8.8 inputs/weights through the register
// port, runs the network and compares readback against hand-computed values.
module tb_mlp;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic [1:0]  addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mlp dut (
    .clk       (clk),
    .rst       (rst),
    .write_en  (write_en),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: one register write, sampled on the next rising edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    write_en  = 1'b1;
    addr      = a;
    writedata = d;
    @(posedge clk);
    #1;
    write_en  = 1'b0;
  endtask

  // Driver: select addr, return readdata registered on the next edge
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    write_en = 1'b0;
    addr     = a;
    @(posedge clk);
    #1;
    d = readdata;
  endtask

  // Load inputs, the same weight set into every hidden neuron, and output weights
  task automatic load(input logic [15:0] x0, input logic [15:0] x1,
                      input logic [15:0] hb, input logic [15:0] hw0, input logic [15:0] hw1,
                      input logic [15:0] ob, input logic [15:0] ow0, input logic [15:0] ow1,
                      input logic [15:0] ow2, input logic [15:0] ow3);
    wr(2'd0, 32'h0);
    wr(2'd1, {16'h0, x0});
    wr(2'd1, {16'h0, x1});
    for (int n = 0; n < 4; n++) begin
      wr(2'd2, {16'h0, hb});
      wr(2'd2, {16'h0, hw0});
      wr(2'd2, {16'h0, hw1});
    end
    wr(2'd0, 32'h8);
    wr(2'd2, {16'h0, ob});
    wr(2'd2, {16'h0, ow0});
    wr(2'd2, {16'h0, ow1});
    wr(2'd2, {16'h0, ow2});
    wr(2'd2, {16'h0, ow3});
    wr(2'd0, 32'h0);
  endtask

  // Wait for irq with a bounded cycle budget; cyc counts edges after the current one
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (irq !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_wait(output int cyc);
    wr(2'd0, 32'h1);
    wait_done(cyc);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1; write_en = 1'b0; addr = 2'd0; writedata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h want 00000000", readdata); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge clk);
    rst = 1'b0;
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00000000", d); end
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 00000000", d); end
  endtask

  task automatic test_ctrl_regs;
    logic [31:0] d;
    wr(2'd0, 32'hFFFF_FFFA);
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0000_00F8) begin n_fail++; $display("FAIL ctrl_rw: got %h want 000000f8", d); end
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL read_addr1: got %h want 00000000", d); end
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL read_addr2: got %h want 00000000", d); end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_basic;
    logic [31:0] d;
    int cyc;
    load(16'hFF00, 16'h0200, 16'h0, 16'h0100, 16'h0100,
         16'h0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run_wait(cyc);
    n_checks++;
    if (cyc !== 23) begin n_fail++; $display("FAIL basic_latency: got %0d want 23", cyc); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %b want 1", irq); end
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0000_0400) begin n_fail++; $display("FAIL basic_out: got %h want 00000400", d); end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL basic_ctrl: got %h want 00000002", d); end
    wr(2'd0, 32'h0);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL done_clear_irq: got %b want 0", irq); end
  endtask

  task automatic test_relu;
    logic [31:0] d;
    int cyc;
    load(16'hFF00, 16'h0200, 16'h0, 16'h0100, 16'h0,
         16'h0080, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run_wait(cyc);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0000_0080) begin n_fail++; $display("FAIL relu_out: got %h want 00000080", d); end
  endtask

  task automatic test_saturate;
    logic [31:0] d;
    int cyc;
    load(16'h7FFF, 16'h7FFF, 16'h0, 16'h7FFF, 16'h7FFF,
         16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0);
    run_wait(cyc);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0000_7FFF) begin n_fail++; $display("FAIL sat_pos: got %h want 00007fff", d); end
    load(16'h7FFF, 16'h7FFF, 16'h0, 16'h7FFF, 16'h7FFF,
         16'h0, 16'h8000, 16'h0, 16'h0, 16'h0);
    run_wait(cyc);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'hFFFF_8000) begin n_fail++; $display("FAIL sat_neg: got %h want ffff8000", d); end
  endtask

  task automatic test_negative_and_rerun;
    logic [31:0] d;
    int cyc;
    load(16'hFF00, 16'h0200, 16'h0, 16'h0100, 16'h0100,
         16'hFE00, 16'h0, 16'h0, 16'h0, 16'h0);
    run_wait(cyc);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'hFFFF_FE00) begin n_fail++; $display("FAIL neg_out: got %h want fffffe00", d); end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL neg_ctrl: got %h want 00000002", d); end
    run_wait(cyc);
    n_checks++;
    if (cyc !== 23) begin n_fail++; $display("FAIL rerun_latency: got %0d want 23", cyc); end
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'hFFFF_FE00) begin n_fail++; $display("FAIL rerun_out: got %h want fffffe00", d); end
  endtask

  task automatic test_input_wrap;
    logic [31:0] d;
    int cyc;
    load(16'hFF00, 16'h0200, 16'h0, 16'h0100, 16'h0100,
         16'h0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0100);
    wr(2'd1, 32'h0300);
    wr(2'd1, 32'hFF00);
    run_wait(cyc);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0000_0800) begin n_fail++; $display("FAIL input_wrap: got %h want 00000800", d); end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] d;
    int cyc;
    load(16'hFF00, 16'h0200, 16'h0, 16'h0100, 16'h0100,
         16'h0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wr(2'd0, 32'h1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL midrun_rst_readdata: got %h want 00000000", readdata); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_irq: got %b want 0", irq); end
    @(negedge clk);
    rst = 1'b0;
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_rst_ctrl: got %h want 00000000", d); end
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_rst_out: got %h want 00000000", d); end
    load(16'hFF00, 16'h0200, 16'h0, 16'h0100, 16'h0100,
         16'h0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run_wait(cyc);
    n_checks++;
    if (cyc !== 23) begin n_fail++; $display("FAIL midrun_reload_latency: got %0d want 23", cyc); end
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0000_0400) begin n_fail++; $display("FAIL midrun_reload_out: got %h want 00000400", d); end
  endtask

  task automatic test_busy_writes;
    logic [31:0] d;
    int cyc;
    load(16'hFF00, 16'h0200, 16'h0, 16'h0100, 16'h0100,
         16'h0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wr(2'd0, 32'h1);
    wr(2'd1, 32'h1234);
    wr(2'd2, 32'h7FFF);
    wr(2'd2, 32'h7FFF);
    wr(2'd0, 32'h9);
    wr(2'd3, 32'hDEAD_BEEF);
    wr(2'd0, 32'h10);
    wait_done(cyc);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL busy_done_timeout: irq %b want 1 within 100 cycles", irq); end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0000_0012) begin n_fail++; $display("FAIL busy_ctrl: got %h want 00000012", d); end
    wr(2'd0, 32'h0);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0000_0400) begin n_fail++; $display("FAIL busy_out: got %h want 00000400", d); end
    run_wait(cyc);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h0000_0400) begin n_fail++; $display("FAIL busy_rerun_out: got %h want 00000400", d); end
  endtask

  initial begin
    test_reset();
    test_ctrl_regs();
    test_basic();
    test_relu();
    test_saturate();
    test_negative_and_rerun();
    test_input_wrap();
    test_reset_midrun();
    test_busy_writes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
